spi_sum_slave: RTL

SPI slave endpoint on the far side of the SPI master's `sclk_o`/`mosi_o`/`miso_i` link. It receives one byte per frame on MOSI. During each frame it returns on MISO the 8-bit sum of the two previously received bytes. It supports all four CPOL/CPHA modes, oversampling SCLK with the system clock. Its deterministic reply stream lets the master's MOSI and MISO paths be checked end to end.

---
 rtl/spi_sum_slave.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_sum_slave.sv
// spi_sum_slave
// SPI slave that receives one byte per frame on MOSI and, during each frame,
// returns on MISO the 8-bit sum of the two bytes received in earlier frames.
// SCLK, SS_N and MOSI are oversampled with clk_i, and all four CPOL/CPHA
// modes are supported.
//
// Ports:
//   clk_i        system clock
//   reset_ni     asynchronous active-low reset
//   sclk_i       SPI clock from the master (asynchronous to clk_i)
//   ss_ni        slave select, active-low (tie low for continuous framing)
//   mosi_i       serial data in, MSB first
//   cpol_i       clock idle level (latched at frame start)
//   cpha_i       0 = sample on leading edge, 1 = sample on trailing edge
//   miso_o       serial reply, MSB first (0 while idle)
//   rx_data_o    last complete received byte
//   rx_valid_o   one-cycle tick when rx_data_o updates
//   tx_data_o    byte being / to be shifted out this frame
//   sum_carry_o  carry out of the sum held in tx_data_o
//   busy_o       high while a frame is in progress
module spi_sum_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       sclk_i,
  input  logic       ss_ni,
  input  logic       mosi_i,
  input  logic       cpol_i,
  input  logic       cpha_i,
  output logic       miso_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic [7:0] tx_data_o,
  output logic       sum_carry_o,
  output logic       busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Synchronizer chains; ss_n resets to its inactive (high) level so a
  // tied-low select produces a clean falling edge after reset.
  logic [SYNC_STAGES-1:0] sclk_sync_reg, ss_sync_reg, mosi_sync_reg;
  logic sclk_d_reg, ss_d_reg;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sclk_sync_reg <= '0;
      ss_sync_reg   <= '1;
      mosi_sync_reg <= '0;
      sclk_d_reg    <= 1'b0;
      ss_d_reg      <= 1'b1;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], sclk_i};
      ss_sync_reg   <= {ss_sync_reg[SYNC_STAGES-2:0], ss_ni};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi_i};
      sclk_d_reg    <= sclk_sync_reg[SYNC_STAGES-1];
      ss_d_reg      <= ss_sync_reg[SYNC_STAGES-1];
    end
  end

  logic sclk_s, ss_s, mosi_s;
  assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
  assign ss_s   = ss_sync_reg[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];

  logic sclk_rise, sclk_fall, ss_fall;
  assign sclk_rise = sclk_s & ~sclk_d_reg;
  assign sclk_fall = ~sclk_s & sclk_d_reg;
  assign ss_fall   = ~ss_s & ss_d_reg;

  logic [1:0] state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic [7:0] rx_sh_reg, rx_sh_next;
  logic [7:0] tx_sh_reg, tx_sh_next;
  logic [7:0] tx_data_reg, tx_data_next;
  logic       carry_reg, carry_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       rx_valid_reg, rx_valid_next;
  logic [7:0] prev1_reg, prev1_next;
  logic [7:0] prev2_reg, prev2_next;
  logic       miso_reg, miso_next;
  logic       cpol_reg, cpol_next;
  logic       cpha_reg, cpha_next;

  logic [8:0] sum9;
  logic       lead_edge, trail_edge, sample_edge, shift_edge;
  logic [7:0] rx_word;

  assign sum9        = {1'b0, prev1_reg} + {1'b0, prev2_reg};
  assign lead_edge   = cpol_reg ? sclk_fall : sclk_rise;
  assign trail_edge  = cpol_reg ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_reg ? trail_edge : lead_edge;
  assign shift_edge  = cpha_reg ? lead_edge : trail_edge;
  assign rx_word     = {rx_sh_reg[6:0], mosi_s};

  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    rx_sh_next    = rx_sh_reg;
    tx_sh_next    = tx_sh_reg;
    tx_data_next  = tx_data_reg;
    carry_next    = carry_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    prev1_next    = prev1_reg;
    prev2_next    = prev2_reg;
    miso_next     = miso_reg;
    cpol_next     = cpol_reg;
    cpha_next     = cpha_reg;

    case (state_reg)
      ST_IDLE: begin
        if (ss_fall || (!ss_s && cnt_reg == 4'd8))
          state_next = ST_LOAD;
      end
      ST_LOAD: begin
        cpol_next    = cpol_i;
        cpha_next    = cpha_i;
        tx_data_next = sum9[7:0];
        carry_next   = sum9[8];
        cnt_next     = 4'd0;
        if (!cpha_i) begin
          // CPHA=0: MSB must already be on the wire before the first sample.
          miso_next  = sum9[7];
          tx_sh_next = {sum9[6:0], 1'b0};
        end else begin
          // CPHA=1: first leading edge presents the MSB.
          tx_sh_next = sum9[7:0];
        end
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (ss_s) begin
          // Select released mid-frame: drop the partial byte.
          state_next = ST_IDLE;
        end else begin
          // For CPHA=0 the trailing edge left over from the previous frame
          // (before any sample of this one) must not shift.
          if (shift_edge && (cpha_reg || cnt_reg != 4'd0)) begin
            miso_next  = tx_sh_reg[7];
            tx_sh_next = {tx_sh_reg[6:0], 1'b0};
          end
          if (sample_edge) begin
            rx_sh_next = rx_word;
            cnt_next   = cnt_reg + 4'd1;
            if (cnt_reg == 4'd7) begin
              state_next    = ST_DONE;
              rx_data_next  = rx_word;
              rx_valid_next = 1'b1;
              prev2_next    = prev1_reg;
              prev1_next    = rx_word;
            end
          end
        end
      end
      default: begin
        state_next = ss_s ? ST_IDLE : ST_LOAD;
      end
    endcase

    if (state_next == ST_IDLE)
      miso_next = 1'b0;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= 4'd0;
      rx_sh_reg    <= 8'h00;
      tx_sh_reg    <= 8'h00;
      tx_data_reg  <= 8'h00;
      carry_reg    <= 1'b0;
      rx_data_reg  <= 8'h00;
      rx_valid_reg <= 1'b0;
      prev1_reg    <= 8'h00;
      prev2_reg    <= 8'h00;
      miso_reg     <= 1'b0;
      cpol_reg     <= 1'b0;
      cpha_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rx_sh_reg    <= rx_sh_next;
      tx_sh_reg    <= tx_sh_next;
      tx_data_reg  <= tx_data_next;
      carry_reg    <= carry_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      prev1_reg    <= prev1_next;
      prev2_reg    <= prev2_next;
      miso_reg     <= miso_next;
      cpol_reg     <= cpol_next;
      cpha_reg     <= cpha_next;
    end
  end

  assign miso_o      = miso_reg;
  assign rx_data_o   = rx_data_reg;
  assign rx_valid_o  = rx_valid_reg;
  assign tx_data_o   = tx_data_reg;
  assign sum_carry_o = carry_reg;
  assign busy_o      = (state_reg != ST_IDLE);

endmodule
